// File: rtl/pwm_pkg.sv
// Shared types and default timing constants for the PWM capture block.
package pwm_pkg;

  typedef enum logic [1:0] {
    SYNC_LOW  = 2'd0,
    WAIT_RISE = 2'd1,
    HIGH      = 2'd2,
    LOW       = 2'd3
  } state_t;

  localparam int PWM_INTERVAL_DEF = 1200;
  localparam int TIMEOUT_DEF      = 2400;

endpackage

// File: rtl/pwm_capture_sync_edge.sv
// Two-flop synchronizer with registered rise/fall detection of the synchronized input.
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic sin_o,
  output logic sin_vld_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q, sync_q, prev_q;
  logic vld_meta_q, vld_sync_q;

  // The valid shift chain tracks the data chain, so sin is only trusted
  // once it reflects the real pin rather than the reset value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q     <= 1'b0;
      sync_q     <= 1'b0;
      prev_q     <= 1'b0;
      vld_meta_q <= 1'b0;
      vld_sync_q <= 1'b0;
    end else begin
      meta_q     <= d_i;
      sync_q     <= meta_q;
      prev_q     <= sync_q;
      vld_meta_q <= 1'b1;
      vld_sync_q <= vld_meta_q;
    end
  end

  assign sin_o     = sync_q;
  assign sin_vld_o = vld_sync_q;
  assign rise_o    = sync_q & ~prev_q;
  assign fall_o    = ~sync_q & prev_q;

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and period of an asynchronous PWM input, with
// stuck-high / stuck-low reporting when no rising edge arrives in time.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter  int PWM_INTERVAL = PWM_INTERVAL_DEF,
  parameter  int TIMEOUT      = TIMEOUT_DEF,
  localparam int DW           = $clog2(PWM_INTERVAL + 1),
  localparam int PW           = $clog2(TIMEOUT + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pwm_in,
  output logic [DW-1:0] duty_value,
  output logic [PW-1:0] period_value,
  output logic          meas_valid,
  output logic          stuck_high,
  output logic          stuck_low
);

  localparam logic [PW-1:0] TO_C   = PW'(TIMEOUT);
  localparam logic [PW-1:0] PI_P   = PW'(PWM_INTERVAL);
  localparam logic [DW-1:0] PI_D   = DW'(PWM_INTERVAL);
  localparam logic [PW-1:0] ONE_P  = PW'(1);

  logic sin, sin_vld, rise, fall;

  sync_edge u_sync_edge (
    .clk      (clk),
    .rst_n    (rst_n),
    .d_i      (pwm_in),
    .sin_o    (sin),
    .sin_vld_o(sin_vld),
    .rise_o   (rise),
    .fall_o   (fall)
  );

  state_t        state_q;
  logic [PW-1:0] hi_cnt_q, per_cnt_q;
  logic [DW-1:0] duty_q, duty_d;
  logic [PW-1:0] period_q;
  logic          valid_q, stuck_hi_q, stuck_lo_q;

  always_comb begin
    duty_d = (hi_cnt_q > PI_P) ? PI_D : hi_cnt_q[DW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SYNC_LOW;
      hi_cnt_q   <= '0;
      per_cnt_q  <= '0;
      duty_q     <= '0;
      period_q   <= '0;
      valid_q    <= 1'b0;
      stuck_hi_q <= 1'b0;
      stuck_lo_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        SYNC_LOW: begin
          if (sin_vld && !sin) state_q <= WAIT_RISE;
        end
        WAIT_RISE: begin
          if (rise) begin
            state_q   <= HIGH;
            hi_cnt_q  <= ONE_P;
            per_cnt_q <= ONE_P;
          end
        end
        HIGH: begin
          if (per_cnt_q == TO_C) begin
            state_q    <= SYNC_LOW;
            duty_q     <= PI_D;
            period_q   <= TO_C;
            stuck_hi_q <= 1'b1;
            stuck_lo_q <= 1'b0;
            valid_q    <= 1'b1;
          end else begin
            per_cnt_q <= per_cnt_q + ONE_P;
            if (fall) state_q <= LOW;
            else if (sin && hi_cnt_q != TO_C) hi_cnt_q <= hi_cnt_q + ONE_P;
          end
        end
        LOW: begin
          // A rising edge on the timeout cycle still closes a normal period.
          if (rise) begin
            state_q    <= HIGH;
            duty_q     <= duty_d;
            period_q   <= per_cnt_q;
            stuck_hi_q <= 1'b0;
            stuck_lo_q <= 1'b0;
            valid_q    <= 1'b1;
            hi_cnt_q   <= ONE_P;
            per_cnt_q  <= ONE_P;
          end else if (per_cnt_q == TO_C) begin
            state_q    <= SYNC_LOW;
            duty_q     <= '0;
            period_q   <= TO_C;
            stuck_hi_q <= 1'b0;
            stuck_lo_q <= 1'b1;
            valid_q    <= 1'b1;
          end else begin
            per_cnt_q <= per_cnt_q + ONE_P;
          end
        end
        default: state_q <= SYNC_LOW;
      endcase
    end
  end

  assign duty_value   = duty_q;
  assign period_value = period_q;
  assign meas_valid   = valid_q;
  assign stuck_high   = stuck_hi_q;
  assign stuck_low    = stuck_lo_q;

endmodule

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 SHALL have parameter PWM_INTERVAL, default 1200, meaning nominal PWM period in clk cycles (full-scale duty).
REQ-002 SHALL have parameter TIMEOUT, default 2400, meaning maximum cycles without a rising edge before stuck reporting; TIMEOUT > PWM_INTERVAL.
REQ-003 SHALL define DW = $clog2(PWM_INTERVAL+1) and PW = $clog2(TIMEOUT+1) as output widths.
REQ-004 clk  input  1  sole clock; all state on posedge clk.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 pwm_in  input  1  asynchronous PWM waveform to measure.
REQ-007 duty_value  output  DW  high time of last measured period, in cycles.
REQ-008 period_value  output  PW  length of last measured period, in cycles.
REQ-009 meas_valid  output  1  one-cycle pulse: duty_value/period_value just updated.
REQ-010 stuck_high  output  1  level: last report was a high-side timeout.
REQ-011 stuck_low  output  1  level: last report was a low-side timeout.

Function
REQ-012 SHALL pass pwm_in through a 2-flop synchronizer, then a registered edge detector; all measurement uses the synchronized signal (sin).
REQ-013 SHALL implement FSM states SYNC_LOW, WAIT_RISE, HIGH, LOW.
REQ-014 SYNC_LOW: stay until sin==0, then -> WAIT_RISE; no counting.
REQ-015 WAIT_RISE: on rising edge of sin -> HIGH, hi_cnt=1, per_cnt=1; no timeout in this state.
REQ-016 HIGH: each cycle per_cnt+1; hi_cnt+1 while sin==1; on falling edge -> LOW, hi_cnt not incremented.
REQ-017 LOW: each cycle per_cnt+1; on rising edge: duty_value=min(hi_cnt, PWM_INTERVAL), period_value=per_cnt (pre-increment), stuck flags cleared, hi_cnt=1, per_cnt=1, stay in measurement (-> HIGH).
REQ-018 meas_valid SHALL assert exactly one cycle, the cycle after the edge or timeout is detected, with outputs already updated.
REQ-019 Timeout: in HIGH or LOW, when per_cnt==TIMEOUT and no rising edge that cycle, SHALL report period_value=TIMEOUT and -> SYNC_LOW.
REQ-020 Timeout in HIGH: duty_value=PWM_INTERVAL, stuck_high=1, stuck_low=0.
REQ-021 Timeout in LOW: duty_value=0, stuck_low=1, stuck_high=0.
REQ-022 Rising edge and per_cnt==TIMEOUT in the same cycle: edge wins (normal report per REQ-017).
REQ-023 Counters SHALL never wrap; per_cnt saturates at TIMEOUT, hi_cnt at TIMEOUT.
REQ-024 duty_value, period_value, stuck flags SHALL hold between reports.

Reset
REQ-025 rst_n low SHALL immediately clear synchronizer, edge register, counters, all outputs to 0, and FSM to SYNC_LOW.
REQ-026 After reset release, no report SHALL occur until sin seen low, then two rising edges (first complete period).
REQ-027 Reset mid-measurement SHALL discard the partial period with no meas_valid.

Structure
REQ-028 pwm_pkg SHALL hold the FSM state enum and the default PWM_INTERVAL/TIMEOUT constants.
REQ-029 SHALL instantiate one sub-module, sync_edge (2-flop synchronizer + rise/fall pulse outputs, async active-low reset).

Verification
REQ-030 Period 1200, high 300, repeated -> from second rising edge, meas_valid once per period, duty_value=300, period_value=1200, stuck flags 0.
REQ-031 Release reset with pwm_in=1, then 300/1200 waveform -> no meas_valid before first full low-then-rise-to-rise period; then 300/1200.
REQ-032 Rise, then hold high (TIMEOUT=2400) -> single meas_valid, duty_value=1200, period_value=2400, stuck_high=1; then no pulses while high.
REQ-033 One valid 300/1200 period, then hold low -> meas_valid with duty_value=0, period_value=2400, stuck_low=1; next normal period clears stuck_low.
REQ-034 High 1500 in period 1600 -> duty_value=1200 (clamped), period_value=1600.
REQ-035 Assert rst_n low mid-HIGH -> all outputs 0 same cycle; no meas_valid for that partial period.
